mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM stage between the EX/MEM register and `MEM_WB_reg`. It executes loads and stores against a single-port data bus with a req/ack handshake, and aligns and extends load data. It stalls the pipeline while a bus access is in flight and presents the final GPR write (`we`/`waddr`/`wdata`) plus a ready strobe that drives `MEM_WB_reg.i_ena`. Non-memory instructions pass through with zero added latency.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width; fixed at 32 for this core.

Ports:
- `clk`  in  1  sole clock
- `resetn`  in  1  reset; asynchronous and active-low
- `i_EX_valid`  in  1  EX/MEM holds a valid instruction
- `i_EX_mem_op`  in  4  memory op code (package `MEMOP_*`)
- `i_EX_addr`  in  32  effective address
- `i_EX_store_data`  in  32  rt value for stores
- `i_EX_GPR_we`  in  1  GPR write enable from EX
- `i_EX_GPR_waddr`  in  5  GPR write address from EX
- `i_EX_GPR_wdata`  in  32  ALU result
- `o_stall`  out  1  freeze PC/IF/ID/EX and EX/MEM
- `o_MEM_ready`  out  1  MEM result valid this cycle; drives `MEM_WB_reg.i_ena`
- `o_MEM_GPR_we`  out  1  GPR write enable to MEM/WB
- `o_MEM_GPR_waddr`  out  5  GPR write address to MEM/WB
- `o_MEM_GPR_wdata`  out  32  GPR write data to MEM/WB
- `o_adel`  out  1  load address-error pulse
- `o_ades`  out  1  store address-error pulse
- `o_dbus_req`  out  1  bus request
- `o_dbus_we`  out  1  bus write
- `o_dbus_addr`  out  32  word-aligned address; bits [1:0] are always 0
- `o_dbus_wstrb`  out  4  byte strobes
- `o_dbus_wdata`  out  32  lane-replicated store data
- `i_dbus_ack`  in  1  bus completion, one cycle
- `i_dbus_rdata`  in  32  read data, valid with ack

## Operation
- Op codes: `NONE`, `LB`, `LBU`, `LH`, `LHU`, `LW`, `SB`, `SH`, `SW`. Any other code is treated as `NONE`.
- State machine states: `IDLE`, `BUSY`, `DONE`.
- IDLE, no valid memory op (invalid instruction or `NONE`):
  - Combinational pass-through: `o_MEM_GPR_*` = `i_EX_GPR_*`.
  - `o_MEM_ready` = `i_EX_valid`; `o_stall` = 0.
  - When `i_EX_valid` = 0, `o_MEM_GPR_we` = 0.
- IDLE, valid memory op, misaligned (half with addr[0] = 1, word with addr[1:0] ≠ 0):
  - No bus access.
  - `o_adel` (load) or `o_ades` (store) = 1 this cycle.
  - `o_MEM_ready` = 1, `o_MEM_GPR_we` = 0, `o_stall` = 0.
- IDLE, valid aligned memory op:
  - `o_stall` = 1, `o_MEM_ready` = 0.
  - Latch op, addr[1:0], waddr, and `we` (forced 0 for stores), then go to BUSY.
  - Latch the bus address, strobes and write data.
- BUSY:
  - `o_dbus_req` = 1, and all bus outputs are held stable until `i_dbus_ack`.
  - `o_stall` = 1.
  - On ack, register the extracted load data and go to DONE.
- DONE, one cycle:
  - `o_MEM_ready` = 1, `o_stall` = 0, `o_MEM_GPR_*` from latched values.
  - Next state is IDLE unconditionally. The still-present EX inputs are not re-accepted this cycle.
- Store strobes and data:
  - `SB`: wstrb = 1 << addr[1:0]; wdata = {4{b}}.
  - `SH`: wstrb = addr[1] ? 1100 : 0011; wdata = {2{h}}.
  - `SW`: wstrb = 1111.
  - Loads: wstrb = 0000.
- Load extraction: select byte by addr[1:0] or half by addr[1]. Sign-extend for `LB`/`LH`, zero-extend for `LBU`/`LHU`.
- `i_dbus_ack` outside BUSY is ignored.

## Timing
- Reset values (async, immediate):
  - State = IDLE; all latched registers = 0.
  - `o_dbus_req`/`o_dbus_we`/`o_dbus_wstrb` = 0.
  - `o_MEM_GPR_we`/`o_adel`/`o_ades` = 0.
  - Other outputs follow the IDLE combinational rules.
- Latency:
  - Non-memory op or exception: 0 cycles.
  - Memory op: request in cycle 1; ack in cycle N ≥ 1 gives DONE in cycle N+1.
  - Minimum occupancy is 3 cycles.
- Ack in the same cycle `o_dbus_req` first rises is legal.
- Reset asserted during BUSY: req drops asynchronously. The pending access is abandoned, and any later ack is ignored.
- Upstream holds EX/MEM stable whenever `o_stall` = 1.

## Structure
- Shared package `mem_pkg` holds:
  - `MEMOP_*` localparams (4-bit).
  - State encodings `ST_IDLE`, `ST_BUSY`, `ST_DONE`.
- Sub-module `load_align`: purely combinational, (op, addr[1:0], rdata) → 32-bit extended value. It is also reusable by a later D-cache.
- Latches use `RegWithWE` instances, written only on IDLE accept.

## Test plan
- ALU op: valid=1, op=`NONE`, waddr=5, wdata=0x1234 → same cycle ready=1, we=1, wdata=0x1234, stall=0, req never asserted.
- `LB` from addr 0x103, rdata=0x80AABBCC, ack after 3 BUSY cycles → stall held 4 cycles; dbus_addr=0x100; DONE wdata=0xFFFFFF80, we=1; `LBU` variant gives 0x00000080.
- `SH` to addr 0x202, data=0x0000BEEF, ack in first BUSY cycle → wstrb=1100, wdata=0xBEEFBEEF, we_bus=1, DONE with GPR we=0.
- `LW` at addr 0x301 → adel=1 same cycle, ready=1, GPR we=0, no req; `SW` at 0x302 → ades=1.
- resetn dropped in BUSY, then ack → req=0 immediately, state IDLE, no DONE and no GPR write afterwards.
- Back-to-back `LW` 0x400 and `LW` 0x404 → exactly two bus transactions, two ready pulses, no duplicate accept in the DONE cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the 4-bit memory op codes, the MEM stage state encoding and
// small decode helpers for load/store classification, alignment checks
// and store lane generation.
package mem_pkg;

  localparam logic [3:0] MEMOP_NONE = 4'd0;
  localparam logic [3:0] MEMOP_LB   = 4'd1;
  localparam logic [3:0] MEMOP_LBU  = 4'd2;
  localparam logic [3:0] MEMOP_LH   = 4'd3;
  localparam logic [3:0] MEMOP_LHU  = 4'd4;
  localparam logic [3:0] MEMOP_LW   = 4'd5;
  localparam logic [3:0] MEMOP_SB   = 4'd6;
  localparam logic [3:0] MEMOP_SH   = 4'd7;
  localparam logic [3:0] MEMOP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEMOP_LB) || (op == MEMOP_LBU) || (op == MEMOP_LH) ||
           (op == MEMOP_LHU) || (op == MEMOP_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes never fault.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    logic half, word;
    half = (op == MEMOP_LH) || (op == MEMOP_LHU) || (op == MEMOP_SH);
    word = (op == MEMOP_LW) || (op == MEMOP_SW);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

  function automatic logic [3:0] store_strb(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (op)
      MEMOP_SB: begin
        case (off)
          2'd0:    s = 4'b0001;
          2'd1:    s = 4'b0010;
          2'd2:    s = 4'b0100;
          default: s = 4'b1000;
        endcase
      end
      MEMOP_SH: s = off[1] ? 4'b1100 : 4'b0011;
      MEMOP_SW: s = 4'b1111;
      default:  s = 4'b0000;
    endcase
    return s;
  endfunction

  // Replicate the store value across all lanes so the strobes alone pick the bytes.
  function automatic logic [31:0] store_lanes(input logic [3:0] op, input logic [31:0] d);
    logic [31:0] w;
    case (op)
      MEMOP_SB: w = {4{d[7:0]}};
      MEMOP_SH: w = {2{d[15:0]}};
      default:  w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// load_align: combinational load data extraction.
// Picks the addressed byte/halfword out of a 32-bit bus word and sign- or
// zero-extends it according to the load op. Non-load ops yield zero.
// Ports: i_op (MEMOP_*), i_off (addr[1:0]), i_rdata (bus word), o_data (result).
module load_align
  import mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (i_off)
      2'd0:    byte_sel = i_rdata[7:0];
      2'd1:    byte_sel = i_rdata[15:8];
      2'd2:    byte_sel = i_rdata[23:16];
      default: byte_sel = i_rdata[31:24];
    endcase
    half_sel = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    case (i_op)
      MEMOP_LB:  o_data = {{24{byte_sel[7]}}, byte_sel};
      MEMOP_LBU: o_data = {24'd0, byte_sel};
      MEMOP_LH:  o_data = {{16{half_sel[15]}}, half_sel};
      MEMOP_LHU: o_data = {16'd0, half_sel};
      MEMOP_LW:  o_data = i_rdata;
      default:   o_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_stage_regwe.sv
// RegWithWE: plain register with write enable and asynchronous
// active-low reset to zero.
// Ports: clk, resetn, i_we (load enable), i_d (next value), o_q (held value).
module RegWithWE #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_we,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) o_q <= '0;
    else if (i_we) o_q <= i_d;
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage between EX/MEM and MEM/WB.
// Runs loads/stores over a single-port req/ack data bus, stalls upstream
// while an access is in flight, and presents the final GPR write with a
// ready strobe for MEM_WB_reg.i_ena. Non-memory instructions and address
// exceptions pass through combinationally with no added latency.
// Ports:
//   clk, resetn                 clock, async active-low reset
//   i_EX_*                      instruction from EX/MEM
//   o_stall                     freeze upstream stages
//   o_MEM_ready, o_MEM_GPR_*    result toward MEM/WB
//   o_adel, o_ades              load/store address-error pulses
//   o_dbus_*, i_dbus_*          data bus request/response
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_EX_valid,
  input  logic [3:0]        i_EX_mem_op,
  input  logic [ADDR_W-1:0] i_EX_addr,
  input  logic [31:0]       i_EX_store_data,
  input  logic              i_EX_GPR_we,
  input  logic [4:0]        i_EX_GPR_waddr,
  input  logic [31:0]       i_EX_GPR_wdata,
  output logic              o_stall,
  output logic              o_MEM_ready,
  output logic              o_MEM_GPR_we,
  output logic [4:0]        o_MEM_GPR_waddr,
  output logic [31:0]       o_MEM_GPR_wdata,
  output logic              o_adel,
  output logic              o_ades,
  output logic              o_dbus_req,
  output logic              o_dbus_we,
  output logic [ADDR_W-1:0] o_dbus_addr,
  output logic [3:0]        o_dbus_wstrb,
  output logic [31:0]       o_dbus_wdata,
  input  logic              i_dbus_ack,
  input  logic [31:0]       i_dbus_rdata
);

  state_e st_q, st_d;

  logic op_ld, op_st, mem_v, mis, accept, capture;

  logic [3:0]        op_q;
  logic [1:0]        off_q;
  logic [4:0]        waddr_q;
  logic              we_q;
  logic [ADDR_W-3:0] baddr_q;
  logic              bwe_q;
  logic [3:0]        wstrb_q;
  logic [31:0]       bwdata_q;
  logic [31:0]       ld_data_q;
  logic [31:0]       ld_align;

  assign op_ld   = is_load(i_EX_mem_op);
  assign op_st   = is_store(i_EX_mem_op);
  assign mem_v   = i_EX_valid && (op_ld || op_st);
  assign mis     = is_misaligned(i_EX_mem_op, i_EX_addr[1:0]);
  assign accept  = (st_q == ST_IDLE) && mem_v && !mis;
  assign capture = (st_q == ST_BUSY) && i_dbus_ack;

  RegWithWE #(.W(4)) u_op_q (
    .clk(clk), .resetn(resetn), .i_we(accept), .i_d(i_EX_mem_op), .o_q(op_q)
  );
  RegWithWE #(.W(2)) u_off_q (
    .clk(clk), .resetn(resetn), .i_we(accept), .i_d(i_EX_addr[1:0]), .o_q(off_q)
  );
  RegWithWE #(.W(5)) u_waddr_q (
    .clk(clk), .resetn(resetn), .i_we(accept), .i_d(i_EX_GPR_waddr), .o_q(waddr_q)
  );
  // Stores never write the register file.
  RegWithWE #(.W(1)) u_we_q (
    .clk(clk), .resetn(resetn), .i_we(accept), .i_d(i_EX_GPR_we && op_ld), .o_q(we_q)
  );
  RegWithWE #(.W(ADDR_W-2)) u_baddr_q (
    .clk(clk), .resetn(resetn), .i_we(accept), .i_d(i_EX_addr[ADDR_W-1:2]), .o_q(baddr_q)
  );
  RegWithWE #(.W(1)) u_bwe_q (
    .clk(clk), .resetn(resetn), .i_we(accept), .i_d(op_st), .o_q(bwe_q)
  );
  RegWithWE #(.W(4)) u_wstrb_q (
    .clk(clk), .resetn(resetn), .i_we(accept),
    .i_d(store_strb(i_EX_mem_op, i_EX_addr[1:0])), .o_q(wstrb_q)
  );
  RegWithWE #(.W(32)) u_bwdata_q (
    .clk(clk), .resetn(resetn), .i_we(accept),
    .i_d(store_lanes(i_EX_mem_op, i_EX_store_data)), .o_q(bwdata_q)
  );

  load_align u_load_align (
    .i_op(op_q), .i_off(off_q), .i_rdata(i_dbus_rdata), .o_data(ld_align)
  );

  RegWithWE #(.W(32)) u_ld_data_q (
    .clk(clk), .resetn(resetn), .i_we(capture), .i_d(ld_align), .o_q(ld_data_q)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st_q <= ST_IDLE;
    else         st_q <= st_d;
  end

  // Bus outputs come straight from registers; req/we/wstrb are gated by the
  // state so an asynchronous reset drops them immediately.
  assign o_dbus_req   = (st_q == ST_BUSY);
  assign o_dbus_we    = (st_q == ST_BUSY) && bwe_q;
  assign o_dbus_wstrb = (st_q == ST_BUSY) ? wstrb_q : 4'b0000;
  assign o_dbus_addr  = {baddr_q, 2'b00};
  assign o_dbus_wdata = bwdata_q;

  always_comb begin
    st_d            = st_q;
    o_stall         = 1'b0;
    o_MEM_ready     = 1'b0;
    o_MEM_GPR_we    = 1'b0;
    o_MEM_GPR_waddr = i_EX_GPR_waddr;
    o_MEM_GPR_wdata = i_EX_GPR_wdata;
    o_adel          = 1'b0;
    o_ades          = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (mem_v && mis) begin
          o_adel      = op_ld;
          o_ades      = op_st;
          o_MEM_ready = 1'b1;
        end else if (mem_v) begin
          o_stall = 1'b1;
          st_d    = ST_BUSY;
        end else begin
          o_MEM_ready  = i_EX_valid;
          o_MEM_GPR_we = i_EX_valid && i_EX_GPR_we;
        end
      end
      ST_BUSY: begin
        o_stall = 1'b1;
        if (i_dbus_ack) st_d = ST_DONE;
      end
      ST_DONE: begin
        // EX/MEM still shows the finished instruction here; it is not looked at.
        o_MEM_ready     = 1'b1;
        o_MEM_GPR_we    = we_q;
        o_MEM_GPR_waddr = waddr_q;
        o_MEM_GPR_wdata = ld_data_q;
        st_d            = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_EX_valid;
  logic [3:0]  i_EX_mem_op;
  logic [31:0] i_EX_addr;
  logic [31:0] i_EX_store_data;
  logic        i_EX_GPR_we;
  logic [4:0]  i_EX_GPR_waddr;
  logic [31:0] i_EX_GPR_wdata;
  logic        o_stall, o_MEM_ready, o_MEM_GPR_we;
  logic [4:0]  o_MEM_GPR_waddr;
  logic [31:0] o_MEM_GPR_wdata;
  logic        o_adel, o_ades, o_dbus_req, o_dbus_we;
  logic [31:0] o_dbus_addr;
  logic [3:0]  o_dbus_wstrb;
  logic [31:0] o_dbus_wdata;
  logic        i_dbus_ack;
  logic [31:0] i_dbus_rdata;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_EX_valid(i_EX_valid), .i_EX_mem_op(i_EX_mem_op), .i_EX_addr(i_EX_addr),
    .i_EX_store_data(i_EX_store_data), .i_EX_GPR_we(i_EX_GPR_we),
    .i_EX_GPR_waddr(i_EX_GPR_waddr), .i_EX_GPR_wdata(i_EX_GPR_wdata),
    .o_stall(o_stall), .o_MEM_ready(o_MEM_ready), .o_MEM_GPR_we(o_MEM_GPR_we),
    .o_MEM_GPR_waddr(o_MEM_GPR_waddr), .o_MEM_GPR_wdata(o_MEM_GPR_wdata),
    .o_adel(o_adel), .o_ades(o_ades), .o_dbus_req(o_dbus_req), .o_dbus_we(o_dbus_we),
    .o_dbus_addr(o_dbus_addr), .o_dbus_wstrb(o_dbus_wstrb), .o_dbus_wdata(o_dbus_wdata),
    .i_dbus_ack(i_dbus_ack), .i_dbus_rdata(i_dbus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    exp_t e;
    e.we = we; e.waddr = waddr; e.wdata = wdata;
    sbq.push_back(e);
  endtask

  // Let inputs settle, then score any result the DUT presents this cycle.
  task automatic settle();
    exp_t e;
    #1;
    if (o_dbus_req && !req_prev) req_rises++;
    req_prev = o_dbus_req;
    if (o_MEM_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("sb_gpr_we", {31'd0, o_MEM_GPR_we}, {31'd0, e.we});
        if (e.we) begin
          chk("sb_waddr", {27'd0, o_MEM_GPR_waddr}, {27'd0, e.waddr});
          chk("sb_wdata", o_MEM_GPR_wdata, e.wdata);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic gwe, input logic [4:0] wa,
                       input logic [31:0] wd);
    i_EX_valid = v; i_EX_mem_op = op; i_EX_addr = addr; i_EX_store_data = sd;
    i_EX_GPR_we = gwe; i_EX_GPR_waddr = wa; i_EX_GPR_wdata = wd;
  endtask

  // Full aligned access: accept cycle, nack BUSY cycles (ack in the last), DONE.
  task automatic mem_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic [4:0] wa, input logic [31:0] rdata,
                        input int nack, input logic exp_we, input logic [31:0] exp_wd,
                        input logic [31:0] exp_baddr, input logic [3:0] exp_strb,
                        input logic exp_bwe, input logic [31:0] exp_bwd, input logic chk_bwd);
    drive(1'b1, op, addr, sd, 1'b1, wa, 32'hCAFE0000);
    i_dbus_ack = 1'b0;
    push(exp_we, wa, exp_wd);
    settle();
    chk({tag, "_acc_stall"}, {31'd0, o_stall}, 32'd1);
    chk({tag, "_acc_ready"}, {31'd0, o_MEM_ready}, 32'd0);
    chk({tag, "_acc_req"}, {31'd0, o_dbus_req}, 32'd0);
    step();
    for (int k = 1; k <= nack; k++) begin
      i_dbus_ack   = (k == nack);
      i_dbus_rdata = (k == nack) ? rdata : 32'hDEADBEEF;
      settle();
      chk({tag, "_busy_req"}, {31'd0, o_dbus_req}, 32'd1);
      chk({tag, "_busy_stall"}, {31'd0, o_stall}, 32'd1);
      chk({tag, "_busy_addr"}, o_dbus_addr, exp_baddr);
      chk({tag, "_busy_wstrb"}, {28'd0, o_dbus_wstrb}, {28'd0, exp_strb});
      chk({tag, "_busy_we"}, {31'd0, o_dbus_we}, {31'd0, exp_bwe});
      if (chk_bwd) chk({tag, "_busy_wdata"}, o_dbus_wdata, exp_bwd);
      step();
    end
    i_dbus_ack = 1'b0;
    i_dbus_rdata = 32'h0;
    settle();
    chk({tag, "_done_ready"}, {31'd0, o_MEM_ready}, 32'd1);
    chk({tag, "_done_stall"}, {31'd0, o_stall}, 32'd0);
    chk({tag, "_done_req"}, {31'd0, o_dbus_req}, 32'd0);
    step();
  endtask

  int rises_before;

  initial begin
    resetn = 1'b0;
    drive(1'b0, MEMOP_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    i_dbus_ack = 1'b0;
    i_dbus_rdata = 32'h0;

    // Reset state
    settle();
    chk("rst_req", {31'd0, o_dbus_req}, 32'd0);
    chk("rst_bwe", {31'd0, o_dbus_we}, 32'd0);
    chk("rst_wstrb", {28'd0, o_dbus_wstrb}, 32'd0);
    chk("rst_gpr_we", {31'd0, o_MEM_GPR_we}, 32'd0);
    chk("rst_adel", {31'd0, o_adel}, 32'd0);
    chk("rst_ades", {31'd0, o_ades}, 32'd0);
    chk("rst_stall", {31'd0, o_stall}, 32'd0);
    chk("rst_ready", {31'd0, o_MEM_ready}, 32'd0);
    step();
    step();
    resetn = 1'b1;
    step();

    // ALU pass-through
    drive(1'b1, MEMOP_NONE, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234);
    push(1'b1, 5'd5, 32'h1234);
    settle();
    chk("alu_ready", {31'd0, o_MEM_ready}, 32'd1);
    chk("alu_we", {31'd0, o_MEM_GPR_we}, 32'd1);
    chk("alu_wdata", o_MEM_GPR_wdata, 32'h1234);
    chk("alu_stall", {31'd0, o_stall}, 32'd0);
    chk("alu_req", {31'd0, o_dbus_req}, 32'd0);
    step();
    // Unknown op code behaves like NONE
    drive(1'b1, 4'hF, 32'h3, 32'h0, 1'b1, 5'd9, 32'h55AA);
    push(1'b1, 5'd9, 32'h55AA);
    settle();
    chk("unk_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("unk_req", {31'd0, o_dbus_req}, 32'd0);
    // Invalid instruction: no ready, no write
    drive(1'b0, MEMOP_LW, 32'h0, 32'h0, 1'b1, 5'd7, 32'h1);
    settle();
    chk("inv_ready", {31'd0, o_MEM_ready}, 32'd0);
    chk("inv_we", {31'd0, o_MEM_GPR_we}, 32'd0);
    chk("inv_stall", {31'd0, o_stall}, 32'd0);
    step();

    // Loads
    mem_op("lb",  MEMOP_LB,  32'h103, 32'h0, 5'd3, 32'h80AABBCC, 3, 1'b1, 32'hFFFFFF80,
           32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);
    mem_op("lbu", MEMOP_LBU, 32'h103, 32'h0, 5'd4, 32'h80AABBCC, 3, 1'b1, 32'h00000080,
           32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);
    mem_op("lb1", MEMOP_LB,  32'h101, 32'h0, 5'd6, 32'h80AABBCC, 2, 1'b1, 32'hFFFFFFBB,
           32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);
    mem_op("lh2", MEMOP_LH,  32'h102, 32'h0, 5'd8, 32'h80AABBCC, 1, 1'b1, 32'hFFFF80AA,
           32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);
    mem_op("lhu", MEMOP_LHU, 32'h100, 32'h0, 5'd10, 32'h80AABBCC, 1, 1'b1, 32'h0000BBCC,
           32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);
    mem_op("lh0", MEMOP_LH,  32'h100, 32'h0, 5'd11, 32'h80AA7BCC, 1, 1'b1, 32'h00007BCC,
           32'h100, 4'b0000, 1'b0, 32'h0, 1'b0);

    // Stores: GPR write must be suppressed even though EX asserts we
    mem_op("sh", MEMOP_SH, 32'h202, 32'h0000BEEF, 5'd12, 32'h0, 1, 1'b0, 32'h0,
           32'h200, 4'b1100, 1'b1, 32'hBEEFBEEF, 1'b1);
    mem_op("sb", MEMOP_SB, 32'h201, 32'h0000005A, 5'd13, 32'h0, 2, 1'b0, 32'h0,
           32'h200, 4'b0010, 1'b1, 32'h5A5A5A5A, 1'b1);
    mem_op("sw", MEMOP_SW, 32'h204, 32'h12345678, 5'd14, 32'h0, 1, 1'b0, 32'h0,
           32'h204, 4'b1111, 1'b1, 32'h12345678, 1'b1);

    // Misaligned accesses
    drive(1'b1, MEMOP_LW, 32'h301, 32'h0, 1'b1, 5'd15, 32'h0);
    push(1'b0, 5'd15, 32'h0);
    settle();
    chk("lw_mis_adel", {31'd0, o_adel}, 32'd1);
    chk("lw_mis_ades", {31'd0, o_ades}, 32'd0);
    chk("lw_mis_ready", {31'd0, o_MEM_ready}, 32'd1);
    chk("lw_mis_stall", {31'd0, o_stall}, 32'd0);
    step();
    chk("lw_mis_req", {31'd0, o_dbus_req}, 32'd0);
    drive(1'b1, MEMOP_SW, 32'h302, 32'h0, 1'b1, 5'd16, 32'h0);
    push(1'b0, 5'd16, 32'h0);
    settle();
    chk("sw_mis_ades", {31'd0, o_ades}, 32'd1);
    chk("sw_mis_adel", {31'd0, o_adel}, 32'd0);
    step();
    chk("sw_mis_req", {31'd0, o_dbus_req}, 32'd0);
    drive(1'b1, MEMOP_LH, 32'h101, 32'h0, 1'b1, 5'd17, 32'h0);
    push(1'b0, 5'd17, 32'h0);
    settle();
    chk("lh_mis_adel", {31'd0, o_adel}, 32'd1);
    step();
    chk("lh_mis_req", {31'd0, o_dbus_req}, 32'd0);

    // Ack outside BUSY is ignored
    drive(1'b0, MEMOP_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    i_dbus_ack = 1'b1;
    settle();
    chk("stray_ack_ready", {31'd0, o_MEM_ready}, 32'd0);
    step();
    i_dbus_ack = 1'b0;
    settle();
    chk("stray_ack_req", {31'd0, o_dbus_req}, 32'd0);
    chk("stray_ack_ready2", {31'd0, o_MEM_ready}, 32'd0);
    step();

    // Reset while BUSY abandons the access
    drive(1'b1, MEMOP_LW, 32'h500, 32'h0, 1'b1, 5'd18, 32'h0);
    settle();
    step();
    settle();
    chk("rb_req_busy", {31'd0, o_dbus_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rb_req_async", {31'd0, o_dbus_req}, 32'd0);
    drive(1'b0, MEMOP_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    resetn = 1'b1;
    i_dbus_ack = 1'b1;
    i_dbus_rdata = 32'h77777777;
    settle();
    chk("rb_ack_ready", {31'd0, o_MEM_ready}, 32'd0);
    chk("rb_ack_req", {31'd0, o_dbus_req}, 32'd0);
    step();
    i_dbus_ack = 1'b0;
    settle();
    chk("rb_after_ready", {31'd0, o_MEM_ready}, 32'd0);
    chk("rb_after_we", {31'd0, o_MEM_GPR_we}, 32'd0);
    chk("rb_after_stall", {31'd0, o_stall}, 32'd0);
    step();

    // Back-to-back word loads: two transactions, two results
    rises_before = req_rises;
    mem_op("lw0", MEMOP_LW, 32'h400, 32'h0, 5'd20, 32'h11111111, 1, 1'b1, 32'h11111111,
           32'h400, 4'b0000, 1'b0, 32'h0, 1'b0);
    mem_op("lw1", MEMOP_LW, 32'h404, 32'h0, 5'd21, 32'h22222222, 1, 1'b1, 32'h22222222,
           32'h404, 4'b0000, 1'b0, 32'h0, 1'b0);
    drive(1'b0, MEMOP_NONE, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      settle();
      step();
    end
    chk("b2b_bus_txns", req_rises - rises_before, 32'd2);
    chk("sb_empty", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
